regfile_rename: RTL and testbench

- Parametrised architectural register file with rename-tag tracking. It sits between the decoder (which reads sources and renames destinations) and the ROB (which commits results).
- Successor to the single-channel regfile, with these additions:
  - explicit busy bits, so ROB id 0 is a legal tag;
  - a tag-checked commit clear;
  - multiple rename, commit and read channels;
  - an optional commit-to-read bypass.

---
 rtl/regfile_rename_pkg.sv | 25 ++
 rtl/regfile_rename_if.sv | 54 +++++
 rtl/regfile_rename_read_port.sv | 58 +++++
 rtl/regfile_rename.sv | 117 +++++++++++
 tb/tb_regfile_rename.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_rename_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_rename_pkg
//  Purpose  : Shared constants for the rename-tracking register file:
//             default geometry (register count, data/ROB widths, port counts)
//             and the hardwired zero-register index.
//  Ports    : none (package)
//  Options  : none
//  Revision : 1.0 - initial release
// ============================================================================
package regfile_rename_pkg;

    // Default geometry, shared by the top level and its bus interface.
    localparam int DEF_NUM_REGS   = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ROB_WIDTH  = 4;
    localparam int DEF_NUM_READ   = 2;
    localparam int DEF_NUM_RENAME = 1;
    localparam int DEF_NUM_COMMIT = 1;

    // Architectural register 0 reads as zero and is never renamed.
    localparam int REG_ZERO = 0;

endpackage : regfile_rename_pkg
`default_nettype wire

// File: rtl/regfile_rename_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_rename_if
//  Purpose  : Bus bundle between decoder/ROB (master) and the rename register
//             file (slave).
//  Ports    : rename  : from_decoder_write_enabled / _reg_id / _rob_id
//             commit  : from_rob_write_enabled / _reg_id / _rob_id / _data
//             read    : rd_addr -> to_decoder_data / _busy / _rob_id
//             All multi-channel fields are flattened, channel 0 in the LSBs.
//  Options  : none
//  Revision : 1.0 - initial release
// ============================================================================
interface regfile_rename_if
    import regfile_rename_pkg::*;
#(
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROB_WIDTH  = DEF_ROB_WIDTH,
    parameter int NUM_READ   = DEF_NUM_READ,
    parameter int NUM_RENAME = DEF_NUM_RENAME,
    parameter int NUM_COMMIT = DEF_NUM_COMMIT
);
    localparam int RAW = $clog2(NUM_REGS);

    logic [NUM_RENAME-1:0]            from_decoder_write_enabled;
    logic [NUM_RENAME*RAW-1:0]        from_decoder_reg_id;
    logic [NUM_RENAME*ROB_WIDTH-1:0]  from_decoder_rob_id;

    logic [NUM_COMMIT-1:0]            from_rob_write_enabled;
    logic [NUM_COMMIT*RAW-1:0]        from_rob_reg_id;
    logic [NUM_COMMIT*ROB_WIDTH-1:0]  from_rob_rob_id;
    logic [NUM_COMMIT*DATA_WIDTH-1:0] from_rob_data;

    logic [NUM_READ*RAW-1:0]          rd_addr;
    logic [NUM_READ*DATA_WIDTH-1:0]   to_decoder_data;
    logic [NUM_READ-1:0]              to_decoder_busy;
    logic [NUM_READ*ROB_WIDTH-1:0]    to_decoder_rob_id;

    modport master (
        output from_decoder_write_enabled, from_decoder_reg_id, from_decoder_rob_id,
        output from_rob_write_enabled, from_rob_reg_id, from_rob_rob_id, from_rob_data,
        output rd_addr,
        input  to_decoder_data, to_decoder_busy, to_decoder_rob_id
    );

    modport slave (
        input  from_decoder_write_enabled, from_decoder_reg_id, from_decoder_rob_id,
        input  from_rob_write_enabled, from_rob_reg_id, from_rob_rob_id, from_rob_data,
        input  rd_addr,
        output to_decoder_data, to_decoder_busy, to_decoder_rob_id
    );

endinterface : regfile_rename_if
`default_nettype wire

// File: rtl/regfile_rename_read_port.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_read_port
//  Purpose  : One combinational decoder read port of the rename register file:
//             indexed read of data/busy/tag, plus an optional same-cycle
//             commit bypass.
//  Ports    : rd_addr_i            source register
//             data_q_i/busy_q_i/tag_q_i  registered file state
//             commit_*_i           same-cycle commit channels (bypass only)
//             data_o/busy_o/rob_id_o     read result
//  Options  : REGFILE_BYPASS_EN - forward same-cycle commit data to the read
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_read_port
    import regfile_rename_pkg::*;
#(
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROB_WIDTH  = DEF_ROB_WIDTH,
    parameter int NUM_COMMIT = DEF_NUM_COMMIT,
    parameter int RAW        = $clog2(NUM_REGS)
) (
    input  wire logic [RAW-1:0]             rd_addr_i,
    input  wire logic [DATA_WIDTH-1:0]      data_q_i [NUM_REGS],
    input  wire logic [NUM_REGS-1:0]        busy_q_i,
    input  wire logic [ROB_WIDTH-1:0]       tag_q_i  [NUM_REGS],
`ifdef REGFILE_BYPASS_EN
    input  wire logic [NUM_COMMIT-1:0]            commit_valid_i,
    input  wire logic [NUM_COMMIT*RAW-1:0]        commit_reg_i,
    input  wire logic [NUM_COMMIT*ROB_WIDTH-1:0]  commit_tag_i,
    input  wire logic [NUM_COMMIT*DATA_WIDTH-1:0] commit_data_i,
`endif
    output logic      [DATA_WIDTH-1:0]      data_o,
    output logic                            busy_o,
    output logic      [ROB_WIDTH-1:0]       rob_id_o
);

    always_comb begin
        data_o   = data_q_i[rd_addr_i];
        busy_o   = busy_q_i[rd_addr_i];
        rob_id_o = tag_q_i[rd_addr_i];
`ifdef REGFILE_BYPASS_EN
        // Ascending scan: the youngest (highest) matching commit channel wins.
        // Busy is re-derived from the stored state each hit, so only the
        // surviving channel's tag decides whether the entry reads as ready.
        for (int c = 0; c < NUM_COMMIT; c++) begin
            if (commit_valid_i[c] && rd_addr_i != RAW'(REG_ZERO) &&
                commit_reg_i[c*RAW +: RAW] == rd_addr_i) begin
                data_o = commit_data_i[c*DATA_WIDTH +: DATA_WIDTH];
                busy_o = busy_q_i[rd_addr_i] &&
                         (tag_q_i[rd_addr_i] != commit_tag_i[c*ROB_WIDTH +: ROB_WIDTH]);
            end
        end
`endif
    end

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/regfile_rename.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_rename
//  Purpose  : Architectural register file with per-register busy bit and
//             rename tag. Decoder renames destinations, ROB commits results
//             with a tag-checked busy clear, flush drops all pending renames.
//  Ports    : clk_in       system clock
//             rst_in       asynchronous active-low reset
//             flush_input  misprediction flush (clears every busy bit)
//             bus          regfile_rename_if.slave (rename/commit/read)
//  Options  : REGFILE_BYPASS_EN - same-cycle commit-to-read forwarding
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_rename
    import regfile_rename_pkg::*;
#(
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROB_WIDTH  = DEF_ROB_WIDTH,
    parameter int NUM_READ   = DEF_NUM_READ,
    parameter int NUM_RENAME = DEF_NUM_RENAME,
    parameter int NUM_COMMIT = DEF_NUM_COMMIT
) (
    input  wire logic       clk_in,
    input  wire logic       rst_in,
    input  wire logic       flush_input,
    regfile_rename_if.slave bus
);

    localparam int RAW = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0] data_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] data_d [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;
    logic [ROB_WIDTH-1:0]  tag_q  [NUM_REGS];
    logic [ROB_WIDTH-1:0]  tag_d  [NUM_REGS];

    logic [NUM_REGS-1:0]   clr;
    logic [RAW-1:0]        creg;
    logic [RAW-1:0]        rreg;

    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        clr    = '0;
        creg   = '0;
        rreg   = '0;

        // Commits: data always lands (youngest channel last, so it wins).
        // The clear decision is overwritten per channel as well, so only the
        // youngest commit to a register gets to compare its tag.
        for (int c = 0; c < NUM_COMMIT; c++) begin
            creg = bus.from_rob_reg_id[c*RAW +: RAW];
            if (bus.from_rob_write_enabled[c] && creg != RAW'(REG_ZERO)) begin
                data_d[creg] = bus.from_rob_data[c*DATA_WIDTH +: DATA_WIDTH];
                clr[creg]    = busy_q[creg] &&
                               (tag_q[creg] == bus.from_rob_rob_id[c*ROB_WIDTH +: ROB_WIDTH]);
            end
        end
        busy_d = busy_q & ~clr;

        // Renames are applied after the clear so they take priority over it.
        // Flush discards them entirely (tags stay stale, busy decides).
        if (flush_input) begin
            busy_d = '0;
        end else begin
            for (int r = 0; r < NUM_RENAME; r++) begin
                rreg = bus.from_decoder_reg_id[r*RAW +: RAW];
                if (bus.from_decoder_write_enabled[r] && rreg != RAW'(REG_ZERO)) begin
                    busy_d[rreg] = 1'b1;
                    tag_d[rreg]  = bus.from_decoder_rob_id[r*ROB_WIDTH +: ROB_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            busy_q <= '0;
        end else begin
            data_q <= data_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        regfile_read_port #(
            .NUM_REGS   (NUM_REGS),
            .DATA_WIDTH (DATA_WIDTH),
            .ROB_WIDTH  (ROB_WIDTH),
            .NUM_COMMIT (NUM_COMMIT),
            .RAW        (RAW)
        ) u_read_port (
            .rd_addr_i      (bus.rd_addr[p*RAW +: RAW]),
            .data_q_i       (data_q),
            .busy_q_i       (busy_q),
            .tag_q_i        (tag_q),
`ifdef REGFILE_BYPASS_EN
            .commit_valid_i (bus.from_rob_write_enabled),
            .commit_reg_i   (bus.from_rob_reg_id),
            .commit_tag_i   (bus.from_rob_rob_id),
            .commit_data_i  (bus.from_rob_data),
`endif
            .data_o         (bus.to_decoder_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .busy_o         (bus.to_decoder_busy[p]),
            .rob_id_o       (bus.to_decoder_rob_id[p*ROB_WIDTH +: ROB_WIDTH])
        );
    end

endmodule : regfile_rename
`default_nettype wire

// File: tb/tb_regfile_rename.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_rename
//  Purpose  : Directed self-checking bench for regfile_rename, built with two
//             rename and two commit channels so same-register conflicts can
//             be exercised.
//  Ports    : none
//  Options  : REGFILE_BYPASS_EN - selects the same-cycle expected values
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_rename;

    localparam int NR  = 32;
    localparam int DW  = 32;
    localparam int RW  = 4;
    localparam int NRD = 2;
    localparam int RAW = 5;

    logic clk;
    logic rst_n;
    logic flush;
    int   total;
    int   bad;

    regfile_rename_if #(
        .NUM_REGS(NR), .DATA_WIDTH(DW), .ROB_WIDTH(RW),
        .NUM_READ(NRD), .NUM_RENAME(2), .NUM_COMMIT(2)
    ) bus ();

    regfile_rename #(
        .NUM_REGS(NR), .DATA_WIDTH(DW), .ROB_WIDTH(RW),
        .NUM_READ(NRD), .NUM_RENAME(2), .NUM_COMMIT(2)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst_n),
        .flush_input (flush),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush                          = 1'b0;
        bus.from_decoder_write_enabled = '0;
        bus.from_decoder_reg_id        = '0;
        bus.from_decoder_rob_id        = '0;
        bus.from_rob_write_enabled     = '0;
        bus.from_rob_reg_id            = '0;
        bus.from_rob_rob_id            = '0;
        bus.from_rob_data              = '0;
    endtask

    task automatic rename(input int ch, input int r, input int t);
        bus.from_decoder_write_enabled[ch]        = 1'b1;
        bus.from_decoder_reg_id[ch*RAW +: RAW]    = RAW'(r);
        bus.from_decoder_rob_id[ch*RW +: RW]      = RW'(t);
    endtask

    task automatic commit(input int ch, input int r, input int t, input logic [DW-1:0] d);
        bus.from_rob_write_enabled[ch]            = 1'b1;
        bus.from_rob_reg_id[ch*RAW +: RAW]        = RAW'(r);
        bus.from_rob_rob_id[ch*RW +: RW]          = RW'(t);
        bus.from_rob_data[ch*DW +: DW]            = d;
    endtask

    // Point read port p at register r and compare data, busy and (optionally) tag.
    task automatic check(input string name, input int p, input int r,
                         input logic [DW-1:0] ed, input logic eb,
                         input logic [RW-1:0] et, input bit ct);
        logic [DW-1:0] od;
        logic          ob;
        logic [RW-1:0] ot;
        bus.rd_addr[p*RAW +: RAW] = RAW'(r);
        #1;
        od = bus.to_decoder_data[p*DW +: DW];
        ob = bus.to_decoder_busy[p];
        ot = bus.to_decoder_rob_id[p*RW +: RW];
        total++;
        assert (od === ed) else begin
            bad++;
            $error("FAIL %s data: got %h want %h", name, od, ed);
        end
        total++;
        assert (ob === eb) else begin
            bad++;
            $error("FAIL %s busy: got %b want %b", name, ob, eb);
        end
        if (ct) begin
            total++;
            assert (ot === et) else begin
                bad++;
                $error("FAIL %s rob_id: got %h want %h", name, ot, et);
            end
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        bus.rd_addr = '0;
        idle();
        tick();
        tick();
        check("reset_r3", 0, 3, 32'h0, 1'b0, 4'h0, 1'b1);
        check("reset_r31", 1, 31, 32'h0, 1'b0, 4'h0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Register 0 ignores renames.
        rename(0, 0, 5);
        tick();
        idle();
        check("r0_rename", 0, 0, 32'h0, 1'b0, 4'h0, 1'b1);

        // Rename then matching commit.
        rename(0, 3, 2);
        tick();
        idle();
        check("r3_busy", 0, 3, 32'h0, 1'b1, 4'h2, 1'b1);
        commit(0, 3, 2, 32'hDEADBEEF);
        tick();
        idle();
        check("r3_commit", 1, 3, 32'hDEADBEEF, 1'b0, 4'h0, 1'b0);

        // Stale commit writes data but leaves the newer rename pending.
        rename(0, 4, 1);
        tick();
        rename(0, 4, 6);
        tick();
        idle();
        commit(0, 4, 1, 32'h11);
        tick();
        idle();
        check("r4_stale", 0, 4, 32'h11, 1'b1, 4'h6, 1'b1);

        // Commit and rename on the same register: rename keeps it busy.
        rename(0, 5, 3);
        tick();
        idle();
        commit(0, 5, 3, 32'h22);
        rename(0, 5, 7);
        tick();
        idle();
        check("r5_commit_rename", 0, 5, 32'h22, 1'b1, 4'h7, 1'b1);

        // Flush clears busy, drops the rename, still writes commit data.
        rename(0, 6, 1);
        rename(1, 7, 2);
        tick();
        idle();
        check("r6_pre_flush", 0, 6, 32'h0, 1'b1, 4'h1, 1'b1);
        check("r7_pre_flush", 1, 7, 32'h0, 1'b1, 4'h2, 1'b1);
        flush = 1'b1;
        rename(0, 8, 4);
        commit(0, 6, 9, 32'h33);
        tick();
        idle();
        check("r6_flush", 0, 6, 32'h33, 1'b0, 4'h0, 1'b0);
        check("r7_flush", 1, 7, 32'h0, 1'b0, 4'h0, 1'b0);
        check("r8_flush", 0, 8, 32'h0, 1'b0, 4'h0, 1'b0);
        check("r5_flush", 1, 5, 32'h22, 1'b0, 4'h0, 1'b0);

        // Two renames to one register: the higher channel wins.
        rename(0, 10, 1);
        rename(1, 10, 8);
        tick();
        idle();
        check("r10_dual_rename", 0, 10, 32'h0, 1'b1, 4'h8, 1'b1);

        // Two commits: higher data wins; a lower-channel tag match is ignored.
        commit(0, 10, 8, 32'hAA);
        commit(1, 10, 3, 32'hBB);
        tick();
        idle();
        check("r10_low_match", 0, 10, 32'hBB, 1'b1, 4'h8, 1'b1);
        commit(0, 10, 3, 32'hCC);
        commit(1, 10, 8, 32'hDD);
        tick();
        idle();
        check("r10_high_match", 1, 10, 32'hDD, 1'b0, 4'h0, 1'b0);

        // ROB id 0 is a legal tag.
        rename(1, 12, 0);
        tick();
        idle();
        check("r12_tag0_busy", 0, 12, 32'h0, 1'b1, 4'h0, 1'b1);
        commit(1, 12, 0, 32'h55);
        tick();
        idle();
        check("r12_tag0_commit", 0, 12, 32'h55, 1'b0, 4'h0, 1'b0);

        // Same-cycle rename is invisible to reads.
        rename(0, 11, 5);
        check("r11_same_cycle", 1, 11, 32'h0, 1'b0, 4'h0, 1'b1);
        tick();
        idle();
        check("r11_next_cycle", 1, 11, 32'h0, 1'b1, 4'h5, 1'b1);

        // Same-cycle commit read: forwarded only with the bypass option.
        rename(0, 9, 2);
        tick();
        idle();
        commit(0, 9, 2, 32'h44);
`ifdef REGFILE_BYPASS_EN
        check("r9_same_cycle", 1, 9, 32'h44, 1'b0, 4'h2, 1'b0);
`else
        check("r9_same_cycle", 1, 9, 32'h0, 1'b1, 4'h2, 1'b1);
`endif
        tick();
        idle();
        check("r9_next_cycle", 1, 9, 32'h44, 1'b0, 4'h0, 1'b0);

        // Mid-cycle async reset clears state at once and beats a pending write.
        commit(0, 13, 0, 32'h77);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_r3", 0, 3, 32'h0, 1'b0, 4'h0, 1'b0);
        check("async_r4", 1, 4, 32'h0, 1'b0, 4'h0, 1'b1);
        tick();
        check("reset_beats_commit", 0, 13, 32'h0, 1'b0, 4'h0, 1'b0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_reset_r11", 1, 11, 32'h0, 1'b0, 4'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_rename
`default_nettype wire
